code_converter_stream: RTL and testbench
========================================

# code_converter_stream

Parametrised, streaming code converter: accepts WIDTH-bit binary values over a valid/ready handshake and returns them in a per-transaction selectable code (binary, Gray, one-hot or thermometer) on a 2**WIDTH-bit output. Successor to the fixed 3-bit combinational encoder. Adds a registered output stage and a skid buffer so it can sit between pipelined producers and consumers without breaking ready-timing paths.

## Interface
- WIDTH, 3, input value width; legal range 1..8
- OUT_W, 2**WIDTH, output width; derived, never overridden
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  producer has a value
- in_ready  out  1  block can accept; asserted when `!rst && !skid_valid`
- in_data  in  WIDTH  binary value
- in_mode  in  2  code select, sampled with in_data: 00 binary, 01 Gray, 10 one-hot, 11 thermometer
- out_valid  out  1  out_data holds a result
- out_ready  in  1  consumer accepts
- out_data  out  OUT_W  encoded value
- out_mode  out  2  mode that produced out_data

## Operation
- Transfer on the input side: `in_valid && in_ready` at a rising edge. Transfer on the output side: `out_valid && out_ready`.
- Encoding, with A = in_data, upper bits always zero:
  - binary: zero-extend A to OUT_W.
  - Gray: `A ^ (A >> 1)`, zero-extended.
  - one-hot: `1 << A`. A=0 gives bit 0 set; never all-zero.
  - thermometer: the low A bits set. A=0 gives all-zero; max A=2**WIDTH-1 sets OUT_W-1 bits.
- Encoding is done before registering. Stored entries hold the encoded data plus the mode.
- Storage has two entries:
  - main register, drives out_*.
  - skid register, holds one entry when the main register is stalled.
- States, derived from {main_valid, skid_valid}:
  - EMPTY {0,0}
  - ONE {1,0}
  - FULL {1,1}
  - {0,1} is illegal and must never occur.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept + output transfer → ONE, main register reloaded.
  - ONE + accept, no output transfer → FULL, new entry to skid.
  - ONE + output transfer only → EMPTY.
  - FULL + output transfer → ONE, skid moves to main.
  - FULL cannot accept, because in_ready=0.
- Ordering is strict FIFO. No entry is dropped or duplicated.
- out_data and out_mode hold stable while `out_valid && !out_ready`.
- in_mode may change every transaction. Each entry carries its own mode.

## Timing
- Reset values: out_valid=0, out_data=0, out_mode=00, skid_valid=0. in_ready reads 0 while rst=1 and 1 on the first cycle after release.
- Latency: a value accepted at edge N is presented with out_valid=1 after edge N, i.e. in cycle N+1.
- Throughput: 1 transfer per cycle while out_ready=1.
- Back-pressure:
  - in_ready falls one cycle after the first stalled accept.
  - in_ready is a function of registered state only; no combinational path from out_ready to in_ready.
- Simultaneous accept and output transfer in ONE: both complete in the same edge.
- Reset mid-operation clears both entries in that edge; in-flight data is discarded.
- in_valid while rst=1 is ignored.

## Structure
- Package `code_pkg`:
  - typedef `code_mode_t`, 2-bit enum: CODE_BIN, CODE_GRAY, CODE_ONEHOT, CODE_THERM.
  - constant `CODE_MAX_WIDTH = 8`.
- Sub-module `code_map`: purely combinational WIDTH → OUT_W mapping with a mode input. Reusable elsewhere and unit-testable alone.
- Top level contains only the two-entry buffer control and the instance of `code_map`.

## Test plan
- WIDTH=3, out_ready=1, send A=5 with each mode in turn → out_data is 0x05, 0x07, 0x20, 0x1F respectively, each one cycle after its accept.
- WIDTH=3, one-hot A=0 and thermometer A=0 → 0x01 and 0x00. Thermometer A=7 → 0x7F.
- Stream A=0..7 in Gray with out_ready=1 → one result per cycle; consecutive out_data differ in exactly 1 bit.
- Hold out_ready=0 and send A=1, then A=2:
  - in_ready=0 after the second accept.
  - out_data stays at the first value.
  - Raise out_ready → outputs appear in order 1 then 2, and in_ready returns to 1 one cycle later.
- Assert rst while FULL → next cycle out_valid=0, out_data=0. Nothing from before reset is emitted afterwards.
- WIDTH=1 and WIDTH=8 with random modes, data and out_ready against a scoreboard → no loss, duplication or reordering. The state {0,1} is never reached (assertion).

Source files
------------

// File: rtl/code_pkg.sv
// Shared types and limits for the code converter family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package code_pkg;

  // Output code selected per transaction; the encoding matches the 2-bit
  // in_mode/out_mode field on the stream ports.
  typedef enum logic [1:0] {
    CODE_BIN    = 2'b00,
    CODE_GRAY   = 2'b01,
    CODE_ONEHOT = 2'b10,
    CODE_THERM  = 2'b11
  } code_mode_t;

  // Largest supported input width; output width is 2**WIDTH, so 8 already
  // means a 256-bit output bus.
  localparam int CODE_MAX_WIDTH = 8;

  // Output width for a given input width.
  function automatic int code_out_w(input int width);
    return 1 << width;
  endfunction

endpackage

// File: rtl/code_map.sv
// Combinational WIDTH-bit binary to OUT_W-bit code mapper (binary, Gray, one-hot, thermometer).
// Latency: zero cycles, purely combinational.
// Backpressure: none; no handshake.
//
// Ports:
//   bin_val  in  WIDTH  binary value to convert
//   mode     in  2      selected code (code_mode_t)
//   code_val out OUT_W  converted value, upper bits zero where unused
module code_map
  import code_pkg::*;
#(
  parameter  int WIDTH = 3,
  localparam int OUT_W = code_out_w(WIDTH)
) (
  input  logic [WIDTH-1:0] bin_val,
  input  code_mode_t       mode,
  output logic [OUT_W-1:0] code_val
);

  logic [OUT_W-1:0] bin_ext;
  logic [OUT_W-1:0] gray_val;
  logic [OUT_W-1:0] one_hot;
  logic [OUT_W-1:0] therm;

  assign bin_ext  = OUT_W'(bin_val);
  assign gray_val = bin_ext ^ (bin_ext >> 1);
  assign one_hot  = OUT_W'(1) << bin_val;
  // Subtracting one from the one-hot word sets every bit below the hot bit:
  // A=0 gives all-zero, A=OUT_W-1 gives OUT_W-1 ones with the MSB clear.
  assign therm    = one_hot - OUT_W'(1);

  always_comb begin
    code_val = bin_ext;
    case (mode)
      CODE_BIN:    code_val = bin_ext;
      CODE_GRAY:   code_val = gray_val;
      CODE_ONEHOT: code_val = one_hot;
      CODE_THERM:  code_val = therm;
      default:     code_val = bin_ext;
    endcase
  end

endmodule

// File: rtl/code_converter_stream.sv
// Streaming code converter: valid/ready in, encode, two-entry (main + skid) registered out.
// Latency: one cycle from input accept to out_valid; one transfer per cycle while out_ready=1.
// Backpressure: in_ready depends only on rst and the skid flop, dropping one cycle after the first stalled accept.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_mode   producer side, in_mode sampled with in_data
//   out_valid/out_ready/out_data/out_mode consumer side, out_mode is the mode that made out_data
module code_converter_stream
  import code_pkg::*;
#(
  parameter  int WIDTH = 3,
  localparam int OUT_W = code_out_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode
);

  // Elaboration-time guard on the supported width range.
  if (WIDTH < 1 || WIDTH > CODE_MAX_WIDTH) begin : g_bad_width
    $error("code_converter_stream: WIDTH must be within 1..%0d", CODE_MAX_WIDTH);
  end

  // Occupancy encoding {main_valid, skid_valid}; 2'b01 is unreachable.
  localparam logic [1:0] ST_EMPTY   = 2'b00;
  localparam logic [1:0] ST_ONE     = 2'b10;
  localparam logic [1:0] ST_FULL    = 2'b11;
  localparam logic [1:0] ST_ILLEGAL = 2'b01;

  logic             main_valid_q, main_valid_d;
  logic [OUT_W-1:0] main_data_q,  main_data_d;
  code_mode_t       main_mode_q,  main_mode_d;
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_data_q,  skid_data_d;
  code_mode_t       skid_mode_q,  skid_mode_d;

  logic [1:0]       state;
  logic             accept;
  logic             out_xfer;
  code_mode_t       in_mode_e;
  logic [OUT_W-1:0] enc_data;

  assign in_mode_e = code_mode_t'(in_mode);

  // Encoding happens ahead of the registers so both entries store final code.
  code_map #(
    .WIDTH (WIDTH)
  ) u_code_map (
    .bin_val  (in_data),
    .mode     (in_mode_e),
    .code_val (enc_data)
  );

  // in_ready comes from the skid flop and rst only, so out_ready never
  // reaches the producer combinationally; rst masks in_valid during reset.
  assign in_ready  = !rst && !skid_valid_q;
  assign accept    = in_valid && in_ready;
  assign out_xfer  = main_valid_q && out_ready;
  assign state     = {main_valid_q, skid_valid_q};

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_mode  = main_mode_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_mode_d  = main_mode_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_mode_d  = skid_mode_q;

    case (state)
      ST_EMPTY: begin
        if (accept) begin
          main_valid_d = 1'b1;
          main_data_d  = enc_data;
          main_mode_d  = in_mode_e;
        end
      end

      ST_ONE: begin
        if (accept && out_xfer) begin
          // Old main leaves and the new entry replaces it on the same edge.
          main_data_d = enc_data;
          main_mode_d = in_mode_e;
        end else if (accept) begin
          // Main is stalled: park the new entry so in_ready can drop a
          // cycle later without losing this transfer.
          skid_valid_d = 1'b1;
          skid_data_d  = enc_data;
          skid_mode_d  = in_mode_e;
        end else if (out_xfer) begin
          main_valid_d = 1'b0;
        end
      end

      ST_FULL: begin
        // in_ready is low here, so only the output side can move.
        if (out_xfer) begin
          main_data_d  = skid_data_q;
          main_mode_d  = skid_mode_q;
          skid_valid_d = 1'b0;
        end
      end

      ST_ILLEGAL: begin
        // Unreachable; recover to EMPTY rather than emit a stale skid entry.
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end

      default: begin
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_mode_q  <= CODE_BIN;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_mode_q  <= CODE_BIN;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_mode_q  <= main_mode_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_mode_q  <= skid_mode_d;
    end
  end

  // The skid entry must never be valid behind an empty main register.
  illegal_state_a : assert property (@(posedge clk) disable iff (rst)
    !(skid_valid_q && !main_valid_q));

endmodule

// File: tb/tb_code_converter_stream.sv
// Self-checking bench: directed table for WIDTH=3, hand sequences for stall and reset, scoreboard for WIDTH=1/8.
// Latency: checks one-cycle accept-to-output and one result per cycle.
// Backpressure: checks in_ready drop/recovery and output hold while stalled.
module tb_code_converter_stream;
  import code_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // WIDTH=3 instance
  logic        a3_in_valid, a3_in_ready, a3_out_valid, a3_out_ready;
  logic [2:0]  a3_in_data;
  logic [1:0]  a3_in_mode, a3_out_mode;
  logic [7:0]  a3_out_data;
  // WIDTH=1 instance
  logic        a1_in_valid, a1_in_ready, a1_out_valid, a1_out_ready;
  logic [0:0]  a1_in_data;
  logic [1:0]  a1_in_mode, a1_out_mode;
  logic [1:0]  a1_out_data;
  // WIDTH=8 instance
  logic        a8_in_valid, a8_in_ready, a8_out_valid, a8_out_ready;
  logic [7:0]  a8_in_data;
  logic [1:0]  a8_in_mode, a8_out_mode;
  logic [255:0] a8_out_data;

  code_converter_stream #(.WIDTH(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(a3_in_valid), .in_ready(a3_in_ready),
    .in_data(a3_in_data), .in_mode(a3_in_mode), .out_valid(a3_out_valid),
    .out_ready(a3_out_ready), .out_data(a3_out_data), .out_mode(a3_out_mode));

  code_converter_stream #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(a1_in_valid), .in_ready(a1_in_ready),
    .in_data(a1_in_data), .in_mode(a1_in_mode), .out_valid(a1_out_valid),
    .out_ready(a1_out_ready), .out_data(a1_out_data), .out_mode(a1_out_mode));

  code_converter_stream #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(a8_in_valid), .in_ready(a8_in_ready),
    .in_data(a8_in_data), .in_mode(a8_in_mode), .out_valid(a8_out_valid),
    .out_ready(a8_out_ready), .out_data(a8_out_data), .out_mode(a8_out_mode));

  int n_cmp = 0;
  int n_bad = 0;
  int illegal_cnt = 0;

  typedef struct {
    logic [1:0] mode;
    logic [2:0] a;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [255:0] d;
    logic [1:0]   m;
  } sb_t;

  vec_t vecs[10];
  sb_t  q1[$];
  sb_t  q8[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference code, built bit by bit.
  function automatic logic [255:0] ref_enc(input int a, input logic [1:0] m);
    logic [255:0] r;
    r = '0;
    case (m)
      2'b00: r = 256'(a);
      2'b01: r = 256'(a ^ (a >> 1));
      2'b10: r[a] = 1'b1;
      default: for (int i = 0; i < a; i++) r[i] = 1'b1;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (u3.skid_valid_q && !u3.main_valid_q) illegal_cnt++;
      if (u1.skid_valid_q && !u1.main_valid_q) illegal_cnt++;
      if (u8.skid_valid_q && !u8.main_valid_q) illegal_cnt++;
    end
  end

  initial begin
    logic [7:0] prev;
    logic [7:0] gexp;
    sb_t        e;
    int         drain;

    vecs[0] = '{2'b00, 3'd5, 8'h05};
    vecs[1] = '{2'b01, 3'd5, 8'h07};
    vecs[2] = '{2'b10, 3'd5, 8'h20};
    vecs[3] = '{2'b11, 3'd5, 8'h1F};
    vecs[4] = '{2'b10, 3'd0, 8'h01};
    vecs[5] = '{2'b11, 3'd0, 8'h00};
    vecs[6] = '{2'b11, 3'd7, 8'h7F};
    vecs[7] = '{2'b01, 3'd7, 8'h04};
    vecs[8] = '{2'b10, 3'd7, 8'h80};
    vecs[9] = '{2'b00, 3'd0, 8'h00};

    rst = 1'b1;
    a3_in_valid = 1'b0; a3_in_data = '0; a3_in_mode = '0; a3_out_ready = 1'b1;
    a1_in_valid = 1'b0; a1_in_data = '0; a1_in_mode = '0; a1_out_ready = 1'b1;
    a8_in_valid = 1'b0; a8_in_data = '0; a8_in_mode = '0; a8_out_ready = 1'b1;

    // Reset state; in_valid while in reset is ignored.
    a3_in_valid = 1'b1; a3_in_data = 3'd3;
    step();
    step();
    chk("rst out_valid", 256'(a3_out_valid), 256'(0));
    chk("rst out_data",  256'(a3_out_data),  256'(0));
    chk("rst out_mode",  256'(a3_out_mode),  256'(0));
    chk("rst in_ready",  256'(a3_in_ready),  256'(0));
    a3_in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("release in_ready", 256'(a3_in_ready), 256'(1));

    // Directed table, back to back with out_ready=1.
    for (int i = 0; i < 10; i++) begin
      a3_in_valid = 1'b1;
      a3_in_data  = vecs[i].a;
      a3_in_mode  = vecs[i].mode;
      step();
      chk($sformatf("vec%0d valid", i), 256'(a3_out_valid), 256'(1));
      chk($sformatf("vec%0d data", i),  256'(a3_out_data),  256'(vecs[i].exp));
      chk($sformatf("vec%0d mode", i),  256'(a3_out_mode),  256'(vecs[i].mode));
    end
    a3_in_valid = 1'b0;
    step();
    chk("table drain valid", 256'(a3_out_valid), 256'(0));

    // Gray stream 0..7: one result per cycle, adjacent codes differ in one bit.
    prev = '0;
    for (int i = 0; i < 8; i++) begin
      a3_in_valid = 1'b1;
      a3_in_data  = 3'(i);
      a3_in_mode  = 2'b01;
      step();
      gexp = 8'(i ^ (i >> 1));
      chk($sformatf("gray%0d valid", i), 256'(a3_out_valid), 256'(1));
      chk($sformatf("gray%0d data", i),  256'(a3_out_data),  256'(gexp));
      if (i > 0)
        chk($sformatf("gray%0d hamming", i), 256'($countones(a3_out_data ^ prev)), 256'(1));
      prev = a3_out_data;
    end
    a3_in_valid = 1'b0;
    step();

    // Stall: fill main and skid, then release.
    a3_out_ready = 1'b0;
    a3_in_valid  = 1'b1; a3_in_mode = 2'b00; a3_in_data = 3'd1;
    step();
    chk("stall1 data",     256'(a3_out_data), 256'(1));
    chk("stall1 in_ready", 256'(a3_in_ready), 256'(1));
    a3_in_data = 3'd2;
    step();
    chk("stall2 in_ready", 256'(a3_in_ready), 256'(0));
    chk("stall2 hold",     256'(a3_out_data), 256'(1));
    a3_in_data = 3'd3;  // must not be taken while in_ready=0
    step();
    chk("stall3 hold",     256'(a3_out_data), 256'(1));
    chk("stall3 valid",    256'(a3_out_valid), 256'(1));
    a3_in_valid  = 1'b0;
    a3_out_ready = 1'b1;
    step();
    chk("release data",     256'(a3_out_data),  256'(2));
    chk("release in_ready", 256'(a3_in_ready),  256'(1));
    step();
    chk("release empty",    256'(a3_out_valid), 256'(0));

    // Reset while FULL discards both entries.
    a3_out_ready = 1'b0;
    a3_in_valid  = 1'b1; a3_in_data = 3'd4;
    step();
    a3_in_data = 3'd5;
    step();
    chk("full before rst", 256'(a3_in_ready), 256'(0));
    rst = 1'b1; a3_in_data = 3'd6;
    step();
    chk("rst mid valid", 256'(a3_out_valid), 256'(0));
    chk("rst mid data",  256'(a3_out_data),  256'(0));
    rst = 1'b0; a3_in_valid = 1'b0; a3_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post rst quiet%0d", i), 256'(a3_out_valid), 256'(0));
    end

    // Random traffic on WIDTH=1 and WIDTH=8 against scoreboards.
    for (int cyc = 0; cyc < 600; cyc++) begin
      a1_in_valid  = 1'($urandom_range(0, 1));
      a1_in_data   = 1'($urandom_range(0, 1));
      a1_in_mode   = 2'($urandom_range(0, 3));
      a1_out_ready = ($urandom_range(0, 2) != 0);
      a8_in_valid  = 1'($urandom_range(0, 1));
      a8_in_data   = 8'($urandom_range(0, 255));
      a8_in_mode   = 2'($urandom_range(0, 3));
      a8_out_ready = ($urandom_range(0, 2) != 0);
      if (a1_out_valid && a1_out_ready) begin
        if (q1.size() == 0) chk("w1 spurious output", 256'(1), 256'(0));
        else begin
          e = q1.pop_front();
          chk("w1 data", 256'(a1_out_data), e.d);
          chk("w1 mode", 256'(a1_out_mode), 256'(e.m));
        end
      end
      if (a8_out_valid && a8_out_ready) begin
        if (q8.size() == 0) chk("w8 spurious output", 256'(1), 256'(0));
        else begin
          e = q8.pop_front();
          chk("w8 data", a8_out_data, e.d);
          chk("w8 mode", 256'(a8_out_mode), 256'(e.m));
        end
      end
      if (a1_in_valid && a1_in_ready) q1.push_back('{ref_enc(int'(a1_in_data), a1_in_mode), a1_in_mode});
      if (a8_in_valid && a8_in_ready) q8.push_back('{ref_enc(int'(a8_in_data), a8_in_mode), a8_in_mode});
      step();
    end

    // Drain with a bounded cycle budget.
    a1_in_valid = 1'b0; a1_out_ready = 1'b1;
    a8_in_valid = 1'b0; a8_out_ready = 1'b1;
    drain = 0;
    while ((q1.size() != 0 || q8.size() != 0) && drain < 20) begin
      if (a1_out_valid && q1.size() != 0) begin
        e = q1.pop_front();
        chk("w1 drain data", 256'(a1_out_data), e.d);
      end
      if (a8_out_valid && q8.size() != 0) begin
        e = q8.pop_front();
        chk("w8 drain data", a8_out_data, e.d);
      end
      step();
      drain++;
    end
    chk("w1 leftover", 256'(q1.size()), 256'(0));
    chk("w8 leftover", 256'(q8.size()), 256'(0));
    chk("w1 idle valid", 256'(a1_out_valid), 256'(0));
    chk("w8 idle valid", 256'(a8_out_valid), 256'(0));
    chk("illegal state count", 256'(illegal_cnt), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
